// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen
// Parametrised pseudo-random word generator presented as a valid/ready stream.
// Supports Fibonacci or Galois feedback and STEPS shifts per output word.
// It recovers from an all-zero state by substituting RESEED, and it measures the
// sequence period by counting accepted words until the state returns to its reference.
//
// Ports:
//   clk          rising-edge clock
//   resetn       synchronous active-low reset; loads seed/tap/mode
//   seed         initial state (sampled in reset and on seed_load)
//   tap          feedback mask (sampled in reset and on seed_load)
//   mode         0 = Fibonacci, 1 = Galois (sampled in reset and on seed_load)
//   seed_load    single-cycle reload request, wins over a same-cycle handshake
//   dout         current state word
//   out_valid    dout is valid
//   out_ready    consumer accepts dout
//   lockup       sticky flag: an all-zero state was replaced by RESEED
//   period       last measured period, in words
//   period_valid period holds a measured value
module lfsr_stream_gen #(
  parameter int               WIDTH  = 16,
  parameter int               STEPS  = 1,
  parameter int               CNT_W  = 32,
  parameter logic [WIDTH-1:0] RESEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] tap,
  input  logic             mode,
  input  logic             seed_load,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lockup,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    PRIME   = 2'd0,
    RECOVER = 2'd1,
    RUN     = 2'd2
  } fsm_t;

  fsm_t             fsm_r, fsm_nxt_s;
  logic [WIDTH-1:0] state_r, state_nxt_s;
  logic [WIDTH-1:0] seed_ref_r, seed_ref_nxt_s;
  logic [WIDTH-1:0] tap_r, tap_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] period_r, period_nxt_s;
  logic             period_valid_r, period_valid_nxt_s;
  logic             lockup_r, lockup_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic [WIDTH-1:0] next_word_s;
  logic             hs_s;

  // One shift of the register in the selected feedback style.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] t,
                                                 input logic             galois);
    logic [WIDTH-1:0] r;
    if (galois) begin
      r = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? t : ZERO_W);
    end else begin
      r = {s[WIDTH-2:0], ^(s & t)};
    end
    return r;
  endfunction

  assign hs_s         = out_valid_r & out_ready;
  assign dout         = state_r;
  assign out_valid    = out_valid_r;
  assign lockup       = lockup_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;

  // Apply STEPS single shifts back to back to form the next output word.
  always_comb begin
    next_word_s = state_r;
    for (int i = 0; i < STEPS; i++) begin
      next_word_s = lfsr_step(next_word_s, tap_r, mode_r);
    end
  end

  // FSM next-state: a reload always restarts priming; a zero produced in RUN forces recovery.
  always_comb begin
    fsm_nxt_s = fsm_r;
    if (seed_load) begin
      fsm_nxt_s = PRIME;
    end else begin
      case (fsm_r)
        PRIME:   fsm_nxt_s = (state_r == ZERO_W) ? RECOVER : RUN;
        RECOVER: fsm_nxt_s = RUN;
        RUN: begin
          if (hs_s && (next_word_s == ZERO_W)) begin
            fsm_nxt_s = RECOVER;
          end else begin
            fsm_nxt_s = RUN;
          end
        end
        default: fsm_nxt_s = PRIME;
      endcase
    end
  end

  // FSM outputs: next values of the datapath registers for the current state.
  always_comb begin
    state_nxt_s        = state_r;
    seed_ref_nxt_s     = seed_ref_r;
    tap_nxt_s          = tap_r;
    mode_nxt_s         = mode_r;
    cnt_nxt_s          = cnt_r;
    period_nxt_s       = period_r;
    period_valid_nxt_s = period_valid_r;
    lockup_nxt_s       = lockup_r;
    out_valid_nxt_s    = (fsm_nxt_s == RUN);
    if (seed_load) begin
      state_nxt_s        = seed;
      seed_ref_nxt_s     = seed;
      tap_nxt_s          = tap;
      mode_nxt_s         = mode;
      cnt_nxt_s          = CNT_ZERO;
      period_nxt_s       = CNT_ZERO;
      period_valid_nxt_s = 1'b0;
      // A zero reload keeps the flag: recovery will set it again anyway.
      lockup_nxt_s       = (seed == ZERO_W) ? lockup_r : 1'b0;
    end else begin
      case (fsm_r)
        PRIME: begin
          state_nxt_s = state_r;
        end
        RECOVER: begin
          state_nxt_s    = RESEED;
          seed_ref_nxt_s = RESEED;
          cnt_nxt_s      = CNT_ZERO;
          lockup_nxt_s   = 1'b1;
        end
        RUN: begin
          if (hs_s) begin
            state_nxt_s = next_word_s;
            if (next_word_s == seed_ref_r) begin
              period_nxt_s       = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
              period_valid_nxt_s = 1'b1;
              cnt_nxt_s          = CNT_ZERO;
            end else begin
              cnt_nxt_s = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end
  end

  // State register and datapath registers; reset loads the configuration inputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fsm_r          <= PRIME;
      state_r        <= seed;
      seed_ref_r     <= seed;
      tap_r          <= tap;
      mode_r         <= mode;
      cnt_r          <= CNT_ZERO;
      period_r       <= CNT_ZERO;
      period_valid_r <= 1'b0;
      lockup_r       <= 1'b0;
      out_valid_r    <= 1'b0;
    end else begin
      fsm_r          <= fsm_nxt_s;
      state_r        <= state_nxt_s;
      seed_ref_r     <= seed_ref_nxt_s;
      tap_r          <= tap_nxt_s;
      mode_r         <= mode_nxt_s;
      cnt_r          <= cnt_nxt_s;
      period_r       <= period_nxt_s;
      period_valid_r <= period_valid_nxt_s;
      lockup_r       <= lockup_nxt_s;
      out_valid_r    <= out_valid_nxt_s;
    end
  end

endmodule
